// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] rem,
  input  logic         dvd_msb,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] next_rem,
  output logic         q_bit
);

  logic [N:0] shifted;
  logic [N:0] trial;

  always_comb begin
    shifted  = {rem, dvd_msb};
    trial    = shifted - {1'b0, divisor};
    // Partial remainder stays below the divisor, so bit N of the trial is a clean borrow.
    q_bit    = ~trial[N];
    next_rem = q_bit ? trial[N-1:0] : shifted[N-1:0];
  end

endmodule

// File: rtl/nbit_seq_div.sv
// Sequential unsigned N-bit restoring divider: one quotient bit per clock, done pulse on completion.
module nbit_seq_div
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         zero_flag,
  output logic         negative_flag,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;

  div_state_t    state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem_r, dvd_r, dsr_r;
  logic [N-1:0]  step_rem;
  logic          step_q;
  logic          accept, last_step;

  div_step #(.N(N)) u_step (
    .rem      (rem_r),
    .dvd_msb  (dvd_r[N-1]),
    .divisor  (dsr_r),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CW'(N - 1)) begin
          last_step = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = (divisor == '0) ? DONE : CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // dvd_r doubles as the quotient shift register: dividend bits leave at the top as quotient bits enter below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem_r       <= '0;
      dvd_r       <= '0;
      dsr_r       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      rem_r <= '0;
      dvd_r <= dividend;
      dsr_r <= divisor;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (busy) begin
      cnt   <= cnt + CW'(1);
      rem_r <= step_rem;
      dvd_r <= {dvd_r[N-2:0], step_q};
      if (last_step) begin
        quotient    <= {dvd_r[N-2:0], step_q};
        remainder   <= step_rem;
        div_by_zero <= 1'b0;
      end
    end
  end

  assign zero_flag     = (quotient == '0);
  assign negative_flag = quotient[N-1];

endmodule

// File: tb/tb_nbit_seq_div.sv
// Directed and randomized checks for nbit_seq_div at N=8.
module tb_nbit_seq_div;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, zero_flag, negative_flag, div_by_zero;
  logic [N-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  int lat, bcnt;

  nbit_seq_div #(.N(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .dividend      (dividend),
    .divisor       (divisor),
    .busy          (busy),
    .done          (done),
    .quotient      (quotient),
    .remainder     (remainder),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .div_by_zero   (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge; returns #1 after the accept edge.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'hA5;
    divisor  = 8'h5A;
  endtask

  task automatic wait_done(output int l, output int b);
    l = 0;
    b = busy ? 1 : 0;
    while (!done && l < 40) begin
      @(posedge clk);
      #1;
      l++;
      if (busy) b++;
    end
  endtask

  task automatic check_res(input string tag, input logic [N-1:0] q, input logic [N-1:0] r,
                           input logic z, input logic n, input logic dz);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_q"}, 32'(quotient), 32'(q));
    check({tag, "_r"}, 32'(remainder), 32'(r));
    check({tag, "_zero"}, 32'(zero_flag), 32'(z));
    check({tag, "_neg"}, 32'(negative_flag), 32'(n));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(dz));
  endtask

  initial begin
    logic [N-1:0] a, b;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q", 32'(quotient), 0);
    check("rst_r", 32'(remainder), 0);
    check("rst_zero", 32'(zero_flag), 1);
    check("rst_neg", 32'(negative_flag), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 0);

    // 100 / 7 = 14 r 2, latency and busy width
    launch(8'd100, 8'd7);
    check("100_7_busy_e0", 32'(busy), 1);
    wait_done(lat, bcnt);
    check("100_7_lat", 32'(lat), N);
    check("100_7_busycnt", 32'(bcnt), N);
    check_res("100_7", 8'd14, 8'd2, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("hold_done", 32'(done), 0);
    check("hold_q", 32'(quotient), 14);
    check("hold_r", 32'(remainder), 2);

    // 255 / 1 = 255 r 0, negative flag
    launch(8'd255, 8'd1);
    wait_done(lat, bcnt);
    check("255_1_lat", 32'(lat), N);
    check_res("255_1", 8'd255, 8'd0, 1'b0, 1'b1, 1'b0);

    // 3 / 10 = 0 r 3, zero flag (back-to-back from DONE)
    launch(8'd3, 8'd10);
    wait_done(lat, bcnt);
    check("3_10_lat", 32'(lat), N);
    check_res("3_10", 8'd0, 8'd3, 1'b1, 1'b0, 1'b0);

    // 5 / 0: done next cycle, busy never asserts
    @(posedge clk);
    #1;
    launch(8'd5, 8'd0);
    check("dbz_busy_e0", 32'(busy), 0);
    wait_done(lat, bcnt);
    check("dbz_lat", 32'(lat), 0);
    check("dbz_busycnt", 32'(bcnt), 0);
    check_res("dbz", 8'hFF, 8'd5, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("dbz_hold_done", 32'(done), 0);
    check("dbz_hold_q", 32'(quotient), 255);
    check("dbz_hold_flag", 32'(div_by_zero), 1);

    // start during CALC is ignored
    launch(8'd100, 8'd7);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    dividend = 8'd9;
    divisor  = 8'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    check("ign_lat", 32'(lat + 3), N);
    check_res("ign", 8'd14, 8'd2, 1'b0, 1'b0, 1'b0);

    // Back-to-back start accepted in the DONE cycle
    launch(8'd9, 8'd2);
    check("b2b_busy_e0", 32'(busy), 1);
    wait_done(lat, bcnt);
    check("b2b_lat", 32'(lat), N);
    check_res("b2b", 8'd4, 8'd1, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-CALC aborts immediately
    launch(8'd100, 8'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_q", 32'(quotient), 0);
    check("abort_r", 32'(remainder), 0);
    check("abort_zero", 32'(zero_flag), 1);
    check("abort_dbz", 32'(div_by_zero), 0);
    repeat (N) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    launch(8'd200, 8'd13);
    wait_done(lat, bcnt);
    check("200_13_lat", 32'(lat), N);
    check_res("200_13", 8'd15, 8'd5, 1'b0, 1'b0, 1'b0);

    // Random sweep, nonzero divisors
    for (int i = 0; i < 2000; i++) begin
      a = N'($urandom_range(0, 255));
      b = N'($urandom_range(1, 255));
      launch(a, b);
      wait_done(lat, bcnt);
      check("rnd_done", 32'(done), 1);
      check("rnd_q", 32'(quotient), 32'(a) / 32'(b));
      check("rnd_recon", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check("rnd_rlt", 32'(remainder < b), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
